mmio_peripherals: RTL and testbench



---
 rtl/mmio_peripherals.sv | 143 ++++++++++++++
 tb/tb_mmio_peripherals.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_peripherals.sv
// Memory-mapped peripherals on the CPU data port: reloadable timer with irq,
// LED register, free-running tick counter and a 4-digit seven-segment scanner.
module mmio_peripherals #(
    parameter logic [31:0] BASE     = 32'h4000_0000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        sel,
    output logic [31:0] read_data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [3:0]  digi_an,
    output logic [7:0]  digi_seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [31:0]      th_q, th_d, tl_q, tl_d, systick_q, systick_d;
    logic [2:0]       tcon_q, tcon_d;
    logic [7:0]       led_q, led_d;
    logic [19:0]      digi_q, digi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic       wr_en, ovf, scan_tick;
    logic [5:0] word;
    logic [31:0] reg_rd;
    logic       unused_addr_bits;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 8'hC0;  4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;  4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;  4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;  4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;  4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;  4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;  4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;  default: glyph = 8'h8E;
        endcase
    endfunction

    assign unused_addr_bits = ^address[1:0];
    assign sel   = (address[31:8] == BASE[31:8]);
    assign word  = address[7:2];
    assign wr_en = sel && MemWrite;

    always_comb begin
        case (word)
            6'd0:    reg_rd = th_q;
            6'd1:    reg_rd = tl_q;
            6'd2:    reg_rd = {29'd0, tcon_q};
            6'd3:    reg_rd = {24'd0, led_q};
            6'd4:    reg_rd = {12'd0, digi_q};
            6'd5:    reg_rd = systick_q;
            default: reg_rd = 32'd0;
        endcase
        read_data = (sel && MemRead) ? reg_rd : 32'd0;
    end

    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_d    = tcon_q;
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;
        ovf       = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

        if (tcon_q[0]) tl_d = ovf ? th_q : tl_q + 32'd1;

        if (wr_en) begin
            case (word)
                6'd0: th_d = write_data;
                6'd1: tl_d = write_data;
                6'd2: begin
                    tcon_d[1:0] = write_data[1:0];
                    if (!write_data[2]) tcon_d[2] = 1'b0;
                end
                6'd3: led_d  = write_data[7:0];
                6'd4: digi_d = write_data[19:0];
                default: ;
            endcase
        end
        // Overflow set is applied last so a simultaneous clear cannot drop an interrupt
        if (ovf && tcon_q[1]) tcon_d[2] = 1'b1;

        scan_tick = (div_q == DIV_LAST);
        div_d     = scan_tick ? '0 : div_q + 1'b1;
        idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
        an_d      = an_q;
        seg_d     = seg_q;
        if (scan_tick) begin
            if (digi_q[16 + idx_d]) begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = glyph(digi_q[{idx_d, 2'b00} +: 4]);
            end else begin
                an_d  = 4'b1111;
                seg_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
            div_q     <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1111;
            seg_q     <= 8'hFF;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign irq      = tcon_q[2];
    assign leds     = led_q;
    assign digi_an  = an_q;
    assign digi_seg = seg_q;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Bench for mmio_peripherals: directed scenarios plus random bus traffic,
// compared every cycle against a register-level behavioural model.
module tb_mmio_peripherals;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, write_data;
    logic        MemRead, MemWrite;
    logic        sel, irq;
    logic [31:0] read_data;
    logic [7:0]  leds, digi_seg;
    logic [3:0]  digi_an;

    always #5 clk = ~clk;

    mmio_peripherals #(.BASE(BASE), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .sel(sel), .read_data(read_data),
        .irq(irq), .leds(leds), .digi_an(digi_an), .digi_seg(digi_seg)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] last_rd;

    logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic [31:0] m_th, m_tl, m_tick;
    logic        m_en, m_ie, m_st;
    logic [7:0]  m_led, m_seg;
    logic [19:0] m_digi;
    logic [3:0]  m_an;
    int          m_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] != BASE[31:8]) return 32'd0;
        case (a[7:0] & 8'hFC)
            8'h00:   return m_th;
            8'h04:   return m_tl;
            8'h08:   return {29'd0, m_st, m_ie, m_en};
            8'h0C:   return {24'd0, m_led};
            8'h10:   return {12'd0, m_digi};
            8'h14:   return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic r, input logic [31:0] a, input logic [31:0] wd, input logic w);
        logic ovf, n_st, we;
        logic [31:0] n_tl;
        logic [7:0] o;
        int k;
        if (r) begin
            m_th = 0; m_tl = 0; m_tick = 0; m_en = 0; m_ie = 0; m_st = 0;
            m_led = 0; m_digi = 0; m_an = 4'hF; m_seg = 8'hFF; m_cyc = 0;
            return;
        end
        we  = w && (a[31:8] == BASE[31:8]);
        o   = a[7:0] & 8'hFC;
        ovf = m_en && (m_tl == 32'hFFFF_FFFF);
        n_tl = m_en ? (ovf ? m_th : m_tl + 1) : m_tl;
        n_st = (we && o == 8'h08 && !wd[2]) ? 1'b0 : m_st;
        if (ovf && m_ie) n_st = 1'b1;
        m_cyc++;
        if (m_cyc % SD == 0) begin
            k = (m_cyc / SD) % 4;
            if (m_digi[16 + k]) begin
                m_an  = ~(4'b0001 << k);
                m_seg = GLYPH[m_digi[4*k +: 4]];
            end else begin
                m_an  = 4'hF;
                m_seg = 8'hFF;
            end
        end
        if (we) begin
            case (o)
                8'h00: m_th = wd;
                8'h04: n_tl = wd;
                8'h08: begin m_en = wd[0]; m_ie = wd[1]; end
                8'h0C: m_led = wd[7:0];
                8'h10: m_digi = wd[19:0];
                default: ;
            endcase
        end
        m_tl = n_tl;
        m_st = n_st;
        m_tick = m_tick + 1;
    endtask

    task automatic tick(input logic r, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr);
        reset = r; address = a; write_data = wd; MemRead = rd; MemWrite = wr;
        #1;
        last_rd = read_data;
        check("sel", {31'd0, sel}, {31'd0, a[31:8] == BASE[31:8]});
        check("rdata", read_data, rd ? m_read(a) : 32'd0);
        check("irq", {31'd0, irq}, {31'd0, m_st});
        check("leds", {24'd0, leds}, {24'd0, m_led});
        check("an", {28'd0, digi_an}, {28'd0, m_an});
        check("seg", {24'd0, digi_seg}, {24'd0, m_seg});
        @(posedge clk);
        model_edge(r, a, wd, wr);
        #1;
    endtask

    task automatic wr32(input logic [7:0] off, input logic [31:0] v);
        tick(1'b0, BASE + {24'd0, off}, v, 1'b0, 1'b1);
    endtask

    task automatic rd32(input logic [7:0] off);
        tick(1'b0, BASE + {24'd0, off}, 32'd0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; address = 0; write_data = 0; MemRead = 0; MemWrite = 0;
        @(posedge clk);
        model_edge(1'b1, 32'd0, 32'd0, 1'b0);
        #1;
        tick(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        check("rst_an", {28'd0, digi_an}, 32'hF);
        check("rst_seg", {24'd0, digi_seg}, 32'hFF);
        for (int i = 0; i < 6; i++) begin
            rd32(8'(i * 4));
            check("rst_read", last_rd, (i == 5) ? 32'd5 : 32'd0);
        end

        // timer reload and irq
        wr32(8'h00, 32'hFFFF_FFFD);
        wr32(8'h04, 32'hFFFF_FFFE);
        wr32(8'h08, 32'h3);
        rd32(8'h04); check("tl_pre", last_rd, 32'hFFFF_FFFE);
        rd32(8'h04); check("tl_max", last_rd, 32'hFFFF_FFFF);
        check("irq_set", {31'd0, irq}, 32'd1);
        rd32(8'h04); check("tl_reload", last_rd, 32'hFFFF_FFFD);
        wr32(8'h08, 32'h3);
        check("irq_clr", {31'd0, irq}, 32'd0);
        wr32(8'h08, 32'h0);
        wr32(8'h04, 32'hFFFF_FFFE);
        wr32(8'h08, 32'h1);
        idle(3);
        check("irq_noie", {31'd0, irq}, 32'd0);

        // set wins over clear in the overflow cycle
        wr32(8'h08, 32'h0);
        wr32(8'h04, 32'hFFFF_FFFE);
        wr32(8'h08, 32'h3);
        wr32(8'h04, 32'hFFFF_FFFF);
        wr32(8'h08, 32'h3);
        check("irq_collide", {31'd0, irq}, 32'd1);
        wr32(8'h04, 32'd5);
        rd32(8'h04); check("tl_w5", last_rd, 32'd5);
        rd32(8'h04); check("tl_w6", last_rd, 32'd6);

        // LED and out-of-map writes
        wr32(8'h0C, 32'h1A5);
        check("leds_w", {24'd0, leds}, 32'hA5);
        rd32(8'h0C); check("led_rd", last_rd, 32'hA5);
        tick(1'b0, 32'h4000_0020, 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick(1'b0, 32'h4000_1004, 32'h1234_5678, 1'b1, 1'b1);
        check("oow_sel", {31'd0, sel}, 32'd0);
        rd32(8'h0C); check("led_keep", last_rd, 32'hA5);

        // display scanner
        tick(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        wr32(8'h10, 32'h000F_12F8);
        idle(3);
        check("scan1_an", {28'd0, digi_an}, 32'hD);
        check("scan1_seg", {24'd0, digi_seg}, 32'h8E);
        idle(12);
        check("scan0_an", {28'd0, digi_an}, 32'hE);
        check("scan0_seg", {24'd0, digi_seg}, 32'h80);
        wr32(8'h10, 32'h0005_12F8);
        idle(3);
        check("mask1_an", {28'd0, digi_an}, 32'hF);
        check("mask1_seg", {24'd0, digi_seg}, 32'hFF);
        idle(6);
        tick(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        check("rstmid_an", {28'd0, digi_an}, 32'hF);
        check("rstmid_seg", {24'd0, digi_seg}, 32'hFF);
        idle(10);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a, wd;
            logic r;
            r = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE | {24'd0, 8'($urandom)};
                default: a = BASE + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
            endcase
            wd = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            tick(r, a, wd, 1'($urandom), 1'($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
